beam_trig_scaler: RTL and testbench

- Sits directly downstream of the dual-beam threshold DSP stage and consumes its per-clock trigger bits, one bit per beam.
- Counts trigger rising edges per beam over a programmable gate period. A per-beam holdoff suppresses retriggers.
- At each period end, snapshots all counts and streams them out over a valid/ready handshake, one beam per beat, for rate monitoring and threshold servoing.

---
 rtl/beam_trig_scaler.sv | 153 +++++++++++++++
 tb/tb_beam_trig_scaler.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_trig_scaler.sv
// Per-beam trigger rate scaler: counts rising edges with retrigger holdoff over a
// programmable gate, then streams the per-beam snapshot out one beam per beat.
module beam_trig_scaler #(
    parameter int NBEAMS      = 2,
    parameter int COUNT_BITS  = 16,
    parameter int PERIOD_BITS = 24,
    parameter int HOLDOFF     = 4,
    localparam int IDX_W  = (NBEAMS > 1) ? $clog2(NBEAMS) : 1,
    localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NBEAMS-1:0]      trig_i,
    input  logic                   enable_i,
    input  logic [PERIOD_BITS-1:0] period_i,
    output logic [COUNT_BITS-1:0]  dat_o,
    output logic [IDX_W-1:0]       dat_idx_o,
    output logic                   dat_last_o,
    output logic                   dat_valid_o,
    input  logic                   dat_ready_i,
    output logic                   ovf_o
);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    localparam logic [COUNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLDOFF);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NBEAMS - 1);

    logic [NBEAMS-1:0]      r_trig_q;
    logic [NBEAMS-1:0]      r_trig_qq;
    logic [HOLD_W-1:0]      r_hold  [NBEAMS];
    logic [COUNT_BITS-1:0]  r_count [NBEAMS];
    logic [COUNT_BITS-1:0]  r_snap  [NBEAMS];
    logic [PERIOD_BITS-1:0] r_pcnt;
    logic [PERIOD_BITS-1:0] r_plen;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [COUNT_BITS-1:0]  r_dat;
    logic                   r_last;
    logic                   r_valid;
    logic                   r_ovf;

    logic                   w_counting;
    logic [PERIOD_BITS-1:0] w_plen;
    logic                   w_terminal;
    logic                   w_accept;
    logic                   w_load;
    logic [IDX_W-1:0]       w_idx_next;
    logic [NBEAMS-1:0]      w_event;
    logic [COUNT_BITS-1:0]  w_snap_next [NBEAMS];

    always_comb begin
        w_counting = enable_i & (period_i != '0);
        // The gate length is taken live from period_i on the first cycle of a period so
        // that a length of 1 is already terminal on that cycle.
        w_plen     = (r_pcnt == '0) ? period_i : r_plen;
        w_terminal = w_counting & (r_pcnt == w_plen - 1'b1);
        w_accept   = r_valid & dat_ready_i;
        // A snapshot is taken when idle, or when the final beat leaves on the same edge.
        w_load     = w_terminal & ((r_state == ST_IDLE) | (w_accept & r_last));
        w_idx_next = r_idx + 1'b1;
        for (int i = 0; i < NBEAMS; i++) begin
            w_event[i] = r_trig_q[i] & ~r_trig_qq[i] & (r_hold[i] == '0) & w_counting;
            w_snap_next[i] = (w_event[i] && (r_count[i] != CNT_MAX)) ?
                             r_count[i] + 1'b1 : r_count[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_trig_q  <= '0;
            r_trig_qq <= '0;
            r_pcnt    <= '0;
            r_plen    <= '0;
            // NOTE: these arrays are a handful of flops each, not RAM, so clearing them
            // in reset is cheap and keeps the first gate after reset deterministic.
            for (int i = 0; i < NBEAMS; i++) begin
                r_hold[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so trig_qq captures the previous trig_q, forming the edge detector.
            r_trig_q  <= trig_i;
            r_trig_qq <= r_trig_q;
            for (int i = 0; i < NBEAMS; i++) begin
                if (w_event[i]) begin
                    r_hold[i] <= HOLD_LOAD;
                end else if (r_hold[i] != '0) begin
                    r_hold[i] <= r_hold[i] - 1'b1;
                end
                if (!w_counting || w_terminal) begin
                    r_count[i] <= '0;
                end else begin
                    r_count[i] <= w_snap_next[i];
                end
            end
            if (!w_counting || w_terminal) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
            if (w_counting && (r_pcnt == '0)) begin
                r_plen <= period_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_dat   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < NBEAMS; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            // Any terminal edge that cannot load a snapshot loses it.
            if (w_terminal && !w_load) begin
                r_ovf <= 1'b1;
            end
            if (w_load) begin
                r_snap  <= w_snap_next;
                r_state <= ST_SEND;
                r_idx   <= '0;
                r_dat   <= w_snap_next[0];
                r_last  <= (NBEAMS == 1);
                r_valid <= 1'b1;
            end else if ((r_state == ST_SEND) && w_accept) begin
                if (r_last) begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else begin
                    r_idx  <= w_idx_next;
                    r_dat  <= r_snap[w_idx_next];
                    r_last <= (w_idx_next == IDX_LAST);
                end
            end
        end
    end

    assign dat_o       = r_dat;
    assign dat_idx_o   = r_idx;
    assign dat_last_o  = r_last;
    assign dat_valid_o = r_valid;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_beam_trig_scaler.sv
// Scenario bench for beam_trig_scaler: expected beats are queued with the stimulus
// and compared by a monitor whenever a beat is accepted.
module tb_beam_trig_scaler;

    localparam int NB = 2;
    localparam int CB = 4;
    localparam int PB = 24;
    localparam int HO = 4;

    typedef struct packed {
        logic          idx;
        logic [CB-1:0] dat;
        logic          last;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NB-1:0] trig_i;
    logic          enable_i;
    logic [PB-1:0] period_i;
    logic [CB-1:0] dat_o;
    logic          dat_idx_o;
    logic          dat_last_o;
    logic          dat_valid_o;
    logic          dat_ready_i;
    logic          ovf_o;

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q [$];

    beam_trig_scaler #(
        .NBEAMS(NB), .COUNT_BITS(CB), .PERIOD_BITS(PB), .HOLDOFF(HO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig_i), .enable_i(enable_i),
        .period_i(period_i), .dat_o(dat_o), .dat_idx_o(dat_idx_o),
        .dat_last_o(dat_last_o), .dat_valid_o(dat_valid_o),
        .dat_ready_i(dat_ready_i), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Beat monitor: every accepted beat must match the head of the queue.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && dat_valid_o === 1'b1 && dat_ready_i === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got idx=%0d dat=%0d last=%0d, required no beat",
                         dat_idx_o, dat_o, dat_last_o);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (dat_idx_o !== e.idx || dat_o !== e.dat || dat_last_o !== e.last) begin
                    bad++;
                    $display("FAIL beat: got idx=%0d dat=%0d last=%0d, required idx=%0d dat=%0d last=%0d",
                             dat_idx_o, dat_o, dat_last_o, e.idx, e.dat, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_beat(input logic idx, input int dat, input logic last);
        beat_t e;
        e.idx  = idx;
        e.dat  = CB'(dat);
        e.last = last;
        exp_q.push_back(e);
    endtask

    function automatic logic [NB-1:0] pat(input int id, input int c);
        logic [NB-1:0] p;
        p = '0;
        case (id)
            0: begin p[0] = (c % 10 == 5) && (c <= 65); p[1] = (c == 10 || c == 30 || c == 50); end
            1: begin p[0] = (c % 2 == 0); p[1] = 1'b1; end
            2: p[0] = (c % 6 == 0) && (c < 120);
            3: begin p[0] = (c == 18); p[1] = (c == 19); end
            4: p[0] = (c == 2 || c == 8);
            5: p[0] = (c == 3);
            6: begin p[0] = (c == 0); p[1] = (c == 2); end
            7: begin p[0] = (c == 0 || c == 6); p[1] = (c == 1); end
            8: p[0] = (c == 1);
            default: p = '0;
        endcase
        return p;
    endfunction

    // Counting cycles 0..ncyc-1 with pattern id, then enable drops.
    task automatic run_gate(input int id, input int plen, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            enable_i = 1'b1;
            period_i = PB'(plen);
            trig_i   = pat(id, c);
            step();
        end
        enable_i = 1'b0;
        trig_i   = '0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && dat_valid_o === 1'b0) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_drain: got %0d beats outstanding valid=%b, required 0 and valid=0",
                     name, exp_q.size(), dat_valid_o);
            exp_q.delete();
        end
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; trig_i = '1; enable_i = 1'b0; period_i = 10; dat_ready_i = 1'b1;
        repeat (3) step();
        @(negedge clk_i);
        total++;
        if ({dat_o, dat_idx_o, dat_last_o, dat_valid_o, ovf_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got dat=%0d idx=%0d last=%b valid=%b ovf=%b, required all 0",
                     dat_o, dat_idx_o, dat_last_o, dat_valid_o, ovf_o);
        end
        step();
        rst_i = 1'b0; trig_i = '0;
        repeat (3) step();
        // Ten gate cycles; the beat is visible in the eleventh cycle after enable rises.
        push_beat(0, 0, 0);
        push_beat(1, 0, 1);
        enable_i = 1'b1; period_i = 10;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 10) enable_i = 1'b0;
            @(negedge clk_i);
            total++;
            if (dat_valid_o !== (k == 10)) begin
                bad++;
                $display("FAIL reset_first_valid: cycle %0d got valid=%b, required %b",
                         k + 1, dat_valid_o, (k == 10));
            end
        end
        wait_drain("reset");
    endtask

    task automatic test_basic();
        push_beat(0, 7, 0);
        push_beat(1, 3, 1);
        run_gate(0, 100, 100);
        wait_drain("basic");
    endtask

    task automatic test_holdoff();
        push_beat(0, 10, 0);
        push_beat(1, 1, 1);
        run_gate(1, 60, 60);
        wait_drain("holdoff");
    endtask

    task automatic test_saturation();
        push_beat(0, 15, 0);
        push_beat(1, 0, 1);
        run_gate(2, 130, 130);
        wait_drain("saturation");
    endtask

    task automatic test_terminal_event();
        push_beat(0, 1, 0);
        push_beat(1, 0, 1);
        run_gate(3, 20, 20);
        wait_drain("terminal_event");
    endtask

    task automatic test_enable_drop();
        bit seen;
        seen = 1'b0;
        run_gate(4, 20, 10);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (dat_valid_o !== 1'b0) seen = 1'b1;
            step();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL enable_drop_no_beat: got valid=1 after partial gate, required valid=0");
        end
        push_beat(0, 1, 0);
        push_beat(1, 0, 1);
        run_gate(5, 20, 20);
        wait_drain("enable_restart");
    endtask

    task automatic test_back_to_back();
        push_beat(0, 1, 0); push_beat(1, 0, 1);
        push_beat(0, 0, 0); push_beat(1, 1, 1);
        push_beat(0, 0, 0); push_beat(1, 0, 1);
        run_gate(6, 2, 6);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk_i);
            total++;
            if (dat_valid_o !== (j < 2)) begin
                bad++;
                $display("FAIL b2b_valid: tail cycle %0d got valid=%b, required %b", j, dat_valid_o, (j < 2));
            end
            if (j < 2) step();
        end
        total++;
        if (ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ovf: got ovf=%b, required 0", ovf_o);
        end
        wait_drain("b2b");
    endtask

    task automatic test_overrun();
        dat_ready_i = 1'b0;
        push_beat(0, 1, 0);
        push_beat(1, 1, 1);
        for (int c = 0; c < 12; c++) begin
            enable_i = 1'b1; period_i = 4; trig_i = pat(7, c);
            @(negedge clk_i);
            if (c >= 4) begin
                total++;
                if ({dat_valid_o, dat_idx_o, dat_o, dat_last_o} !== {1'b1, 1'b0, 4'd1, 1'b0}) begin
                    bad++;
                    $display("FAIL overrun_hold: cycle %0d got valid=%b idx=%0d dat=%0d last=%b, required 1 0 1 0",
                             c, dat_valid_o, dat_idx_o, dat_o, dat_last_o);
                end
            end
            if (c == 4 || c == 8) begin
                total++;
                if (ovf_o !== (c == 8)) begin
                    bad++;
                    $display("FAIL overrun_ovf: cycle %0d got ovf=%b, required %b", c, ovf_o, (c == 8));
                end
            end
            step();
        end
        enable_i = 1'b0; trig_i = '0;
        dat_ready_i = 1'b1;
        wait_drain("overrun");
        @(negedge clk_i);
        total++;
        if (ovf_o !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky: got ovf=%b, required 1", ovf_o);
        end
        step();
    endtask

    task automatic test_reset_in_send();
        dat_ready_i = 1'b0;
        run_gate(8, 5, 5);
        @(negedge clk_i);
        total++;
        if (dat_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL send_before_reset: got valid=%b, required 1", dat_valid_o);
        end
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if ({dat_valid_o, dat_o, dat_idx_o, dat_last_o, ovf_o} !== '0) begin
            bad++;
            $display("FAIL reset_in_send: got valid=%b dat=%0d idx=%0d last=%b ovf=%b, required all 0",
                     dat_valid_o, dat_o, dat_idx_o, dat_last_o, ovf_o);
        end
        exp_q.delete();
        dat_ready_i = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_holdoff();
        test_saturation();
        test_terminal_event();
        test_enable_drop();
        test_back_to_back();
        test_overrun();
        test_reset_in_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
